// File: rtl/alu64bit_seq_ctrl.sv
// alu64bit_seq_ctrl
//   Sequencing front-end for the combinational alu64bit core. Accepts one
//   operation per in_valid/in_ready handshake, registers the operands onto
//   the ALU inputs, waits SETTLE_CYCLES for the ripple path to resolve,
//   captures s/cout and presents them on an out_valid/out_ready port.
//
// Parameters
//   SETTLE_CYCLES : cycles from operand launch to result capture (1..255)
//   CNT_W         : width of the completed-operation counter
//
// Ports
//   clk, rst_n            : rising-edge clock, synchronous active-low reset
//   in_valid/in_ready     : request handshake
//   in_a, in_b, in_cin    : operands and carry-in
//   in_op                 : ALU op code, passed through unmodified
//   alu_a/b/cin/op        : registered drive to alu64bit
//   alu_s, alu_cout       : result from alu64bit
//   out_valid/out_ready   : result handshake
//   out_s, out_cout       : captured result
//   op_count              : completed output handshakes, wraps silently
//   out_zero, out_neg     : result flags, only with ALU_SEQ_FLAGS_EN defined
//
// Build option
//   ALU_SEQ_FLAGS_EN : adds out_zero/out_neg, captured with out_s.

module alu64bit_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic             in_cin,
    input  logic [1:0]       in_op,
    output logic [63:0]      alu_a,
    output logic [63:0]      alu_b,
    output logic             alu_cin,
    output logic [1:0]       alu_op,
    input  logic [63:0]      alu_s,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_s,
    output logic             out_cout,
    output logic [CNT_W-1:0] op_count
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_neg
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Counter value on the capture edge; counter starts at 0 on acceptance.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      alu_a_q, alu_a_d;
    logic [63:0]      alu_b_q, alu_b_d;
    logic             alu_cin_q, alu_cin_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic [63:0]      out_s_q, out_s_d;
    logic             out_cout_q, out_cout_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
`ifdef ALU_SEQ_FLAGS_EN
    logic             out_zero_q, out_zero_d;
    logic             out_neg_q, out_neg_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        alu_op_d    = alu_op_q;
        out_s_d     = out_s_q;
        out_cout_d  = out_cout_q;
        op_count_d  = op_count_q;
`ifdef ALU_SEQ_FLAGS_EN
        out_zero_d  = out_zero_q;
        out_neg_d   = out_neg_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    alu_a_d    = in_a;
                    alu_b_d    = in_b;
                    alu_cin_d  = in_cin;
                    alu_op_d   = in_op;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SETTLE_LAST) begin
                    out_s_d     = alu_s;
                    out_cout_d  = alu_cout;
`ifdef ALU_SEQ_FLAGS_EN
                    out_zero_d  = (alu_s == '0);
                    out_neg_d   = alu_s[63];
`endif
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            alu_op_q    <= '0;
            out_s_q     <= '0;
            out_cout_q  <= 1'b0;
            op_count_q  <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            out_zero_q  <= 1'b0;
            out_neg_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            alu_op_q    <= alu_op_d;
            out_s_q     <= out_s_d;
            out_cout_q  <= out_cout_d;
            op_count_q  <= op_count_d;
`ifdef ALU_SEQ_FLAGS_EN
            out_zero_q  <= out_zero_d;
            out_neg_q   <= out_neg_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign alu_op    = alu_op_q;
    assign out_s     = out_s_q;
    assign out_cout  = out_cout_q;
    assign op_count  = op_count_q;
`ifdef ALU_SEQ_FLAGS_EN
    assign out_zero  = out_zero_q;
    assign out_neg   = out_neg_q;
`endif

endmodule

// File: tb/tb_alu64bit_seq_ctrl.sv
// Testbench for alu64bit_seq_ctrl. Instance A: SETTLE_CYCLES=4, CNT_W=16.
// Instance B: SETTLE_CYCLES=1, CNT_W=2 (back-to-back and counter wrap).
// Each instance is closed around an adder stub standing in for alu64bit.

module tb_alu64bit_seq_ctrl;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [1:0]  op;
        logic [63:0] s;
        logic        cout;
        logic        zero;
        logic        neg;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A ----------------
    logic        rst_a_n, in_valid_a, in_ready_a, in_cin_a, alu_cin_a, alu_cout_a;
    logic        out_valid_a, out_ready_a, out_cout_a;
    logic [63:0] in_a_a, in_b_a, alu_a_a, alu_b_a, alu_s_a, out_s_a;
    logic [1:0]  in_op_a, alu_op_a;
    logic [15:0] op_count_a;
`ifdef ALU_SEQ_FLAGS_EN
    logic        out_zero_a, out_neg_a, out_zero_b, out_neg_b;
`endif

    assign {alu_cout_a, alu_s_a} = {1'b0, alu_a_a} + {1'b0, alu_b_a} + {64'd0, alu_cin_a};

    alu64bit_seq_ctrl #(.SETTLE_CYCLES(4), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_a_n),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_a(in_a_a), .in_b(in_b_a), .in_cin(in_cin_a), .in_op(in_op_a),
        .alu_a(alu_a_a), .alu_b(alu_b_a), .alu_cin(alu_cin_a), .alu_op(alu_op_a),
        .alu_s(alu_s_a), .alu_cout(alu_cout_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_s(out_s_a), .out_cout(out_cout_a), .op_count(op_count_a)
`ifdef ALU_SEQ_FLAGS_EN
        , .out_zero(out_zero_a), .out_neg(out_neg_a)
`endif
    );

    // ---------------- instance B ----------------
    logic        rst_b_n, in_valid_b, in_ready_b, in_cin_b, alu_cin_b, alu_cout_b;
    logic        out_valid_b, out_ready_b, out_cout_b;
    logic [63:0] in_a_b, in_b_b, alu_a_b, alu_b_b, alu_s_b, out_s_b;
    logic [1:0]  in_op_b, alu_op_b;
    logic [1:0]  op_count_b;

    assign {alu_cout_b, alu_s_b} = {1'b0, alu_a_b} + {1'b0, alu_b_b} + {64'd0, alu_cin_b};

    alu64bit_seq_ctrl #(.SETTLE_CYCLES(1), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_b_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_a(in_a_b), .in_b(in_b_b), .in_cin(in_cin_b), .in_op(in_op_b),
        .alu_a(alu_a_b), .alu_b(alu_b_b), .alu_cin(alu_cin_b), .alu_op(alu_op_b),
        .alu_s(alu_s_b), .alu_cout(alu_cout_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_s(out_s_b), .out_cout(out_cout_b), .op_count(op_count_b)
`ifdef ALU_SEQ_FLAGS_EN
        , .out_zero(out_zero_b), .out_neg(out_neg_b)
`endif
    );

    vec_t        va[6];
    vec_t        vb[5];
    logic [1:0]  cnt_b_exp[5];
    int          exp_cnt_a = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Steps until out_valid_a is seen or the budget runs out; returns edges waited.
    task automatic wait_valid_a(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!out_valid_a && lat < 20);
    endtask

    task automatic run_vec_a(input vec_t v, input int idx);
        int lat;
        in_a_a = v.a; in_b_a = v.b; in_cin_a = v.cin; in_op_a = v.op;
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        chk($sformatf("v%0d_acc_in_ready", idx), {63'd0, in_ready_a}, 64'd0);
        chk($sformatf("v%0d_alu_a", idx), alu_a_a, v.a);
        chk($sformatf("v%0d_alu_b", idx), alu_b_a, v.b);
        chk($sformatf("v%0d_alu_cin_op", idx), {61'd0, alu_cin_a, alu_op_a}, {61'd0, v.cin, v.op});
        wait_valid_a(lat);
        chk($sformatf("v%0d_latency", idx), 64'(lat), 64'd4);
        chk($sformatf("v%0d_out_s", idx), out_s_a, v.s);
        chk($sformatf("v%0d_out_cout", idx), {63'd0, out_cout_a}, {63'd0, v.cout});
`ifdef ALU_SEQ_FLAGS_EN
        chk($sformatf("v%0d_flags", idx), {62'd0, out_zero_a, out_neg_a}, {62'd0, v.zero, v.neg});
`endif
        step();
        exp_cnt_a++;
        chk($sformatf("v%0d_hs_out_valid", idx), {63'd0, out_valid_a}, 64'd0);
        chk($sformatf("v%0d_hs_in_ready", idx), {63'd0, in_ready_a}, 64'd1);
        chk($sformatf("v%0d_op_count", idx), {48'd0, op_count_a}, 64'(exp_cnt_a));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int acc_prev;

        //            a                      b                      cin   op     s                      cout  zero  neg
        va[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                 1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
        va[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                 1'b0, 2'b00, 64'h0,                 1'b1, 1'b1, 1'b0};
        va[2] = '{64'h0,                 64'h0,                 1'b1, 2'b01, 64'h1,                 1'b0, 1'b0, 1'b0};
        va[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 2'b11, 64'h1,                 1'b1, 1'b0, 1'b0};
        va[4] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 2'b10, 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0};
        va[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0,                 1'b1, 2'b01, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1};

        vb[0] = '{64'h1,                 64'h2,                 1'b0, 2'b00, 64'h3,                 1'b0, 1'b0, 1'b0};
        vb[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1};
        vb[2] = '{64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 2'b10, 64'h0000_0002_0000_0000, 1'b0, 1'b0, 1'b0};
        vb[3] = '{64'hF000_0000_0000_0000, 64'h1000_0000_0000_0000, 1'b0, 2'b11, 64'h0,                 1'b1, 1'b1, 1'b0};
        vb[4] = '{64'hDEAD_BEEF_0000_0000, 64'h0000_0000_CAFE_F00D, 1'b0, 2'b00, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0, 1'b1};
        cnt_b_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        in_valid_a = 1'b0; in_a_a = '1; in_b_a = '1; in_cin_a = 1'b1; in_op_a = 2'b11;
        in_valid_b = 1'b0; in_a_b = '0; in_b_b = '0; in_cin_b = 1'b0; in_op_b = 2'b00;
        out_ready_a = 1'b1; out_ready_b = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_in_ready", {63'd0, in_ready_a}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("rst_alu_a", alu_a_a, 64'd0);
        chk("rst_alu_b", alu_b_a, 64'd0);
        chk("rst_cin_op_cout", {61'd0, alu_cin_a, alu_op_a}, 64'd0);
        chk("rst_out_s", out_s_a, 64'd0);
        chk("rst_out_cout", {63'd0, out_cout_a}, 64'd0);
        chk("rst_op_count", {48'd0, op_count_a}, 64'd0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("rst_flags", {62'd0, out_zero_a, out_neg_a}, 64'd0);
`endif
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        step();

        // Table-driven operations, out_ready held high
        for (int i = 0; i < 6; i++) run_vec_a(va[i], i);

        // Output backpressure
        out_ready_a = 1'b0;
        in_a_a = 64'h5; in_b_a = 64'h7; in_cin_a = 1'b0; in_op_a = 2'b00;
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        wait_valid_a(lat);
        chk("bp_latency", 64'(lat), 64'd4);
        chk("bp_out_s", out_s_a, 64'hC);
        in_a_a = 64'hAAAA_AAAA_AAAA_AAAA; in_b_a = 64'h5555_5555_5555_5555;
        in_cin_a = 1'b1; in_op_a = 2'b01;
        in_valid_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("bp%0d_out_valid", i), {63'd0, out_valid_a}, 64'd1);
            chk($sformatf("bp%0d_out_s", i), out_s_a, 64'hC);
            chk($sformatf("bp%0d_in_ready", i), {63'd0, in_ready_a}, 64'd0);
            chk($sformatf("bp%0d_alu_a", i), alu_a_a, 64'h5);
        end
        out_ready_a = 1'b1;
        step();
        exp_cnt_a++;
        chk("bp_hs_out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("bp_hs_in_ready", {63'd0, in_ready_a}, 64'd1);
        chk("bp_hs_op_count", {48'd0, op_count_a}, 64'(exp_cnt_a));
        step();
        in_valid_a = 1'b0;
        chk("bp2_acc_in_ready", {63'd0, in_ready_a}, 64'd0);
        chk("bp2_alu_a", alu_a_a, 64'hAAAA_AAAA_AAAA_AAAA);
        wait_valid_a(lat);
        chk("bp2_latency", 64'(lat), 64'd4);
        chk("bp2_out_s", out_s_a, 64'h0);
        chk("bp2_out_cout", {63'd0, out_cout_a}, 64'd1);
        step();
        exp_cnt_a++;
        chk("bp2_op_count", {48'd0, op_count_a}, 64'(exp_cnt_a));
        chk("bp2_hold_out_s", out_s_a, 64'h0);

        // Reset mid-SETTLE: two edges after acceptance
        in_a_a = 64'h1234; in_b_a = 64'h1; in_cin_a = 1'b0; in_op_a = 2'b00;
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        step();
        rst_a_n = 1'b0;
        step();
        rst_a_n = 1'b1;
        exp_cnt_a = 0;
        chk("mrst_out_valid", {63'd0, out_valid_a}, 64'd0);
        chk("mrst_in_ready", {63'd0, in_ready_a}, 64'd1);
        chk("mrst_alu_a", alu_a_a, 64'd0);
        chk("mrst_op_count", {48'd0, op_count_a}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("mrst%0d_no_result", i), {62'd0, out_valid_a, in_ready_a}, 64'd1);
        end
        run_vec_a(va[0], 100);

        // SETTLE_CYCLES=1 back-to-back with CNT_W=2 wrap
        acc_prev = 0;
        for (int k = 0; k < 5; k++) begin
            in_a_b = vb[k].a; in_b_b = vb[k].b; in_cin_b = vb[k].cin; in_op_b = vb[k].op;
            in_valid_b = 1'b1;
            step();
            chk($sformatf("b%0d_acc_in_ready", k), {63'd0, in_ready_b}, 64'd0);
            chk($sformatf("b%0d_alu_a", k), alu_a_b, vb[k].a);
            if (k > 0) chk($sformatf("b%0d_period", k), 64'(cyc - acc_prev), 64'd3);
            acc_prev = cyc;
            step();
            chk($sformatf("b%0d_out_valid", k), {63'd0, out_valid_b}, 64'd1);
            chk($sformatf("b%0d_out_s", k), out_s_b, vb[k].s);
            chk($sformatf("b%0d_out_cout", k), {63'd0, out_cout_b}, {63'd0, vb[k].cout});
            step();
            chk($sformatf("b%0d_hs", k), {62'd0, out_valid_b, in_ready_b}, 64'd1);
            chk($sformatf("b%0d_op_count", k), {62'd0, op_count_b}, {62'd0, cnt_b_exp[k]});
        end
        in_valid_b = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu64bit_seq_ctrl.md
# alu64bit_seq_ctrl

Sequencing front-end for the combinational `alu64bit` core. It accepts one operation per valid/ready handshake and registers the operands onto the ALU inputs. It then waits a fixed number of settle cycles for the ripple-carry path to resolve, captures `s`/`cout`, and presents the result on a valid/ready output port. It sits directly upstream of `alu64bit` (drives `a`, `b`, `cin`, `op`) and directly downstream of it (consumes `s`, `cout`).

## Interface
- `SETTLE_CYCLES`, default 4: cycles from operand launch to result capture; legal range 1..255.
- `CNT_W`, default 16: width of the completed-operation counter.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  block can accept a request
- `in_a`, `in_b`  in  64 each  operands
- `in_cin`  in  1  carry-in
- `in_op`  in  2  ALU op code, passed through unmodified
- `alu_a`, `alu_b`  out  64 each  to `alu64bit.a` / `.b`
- `alu_cin`  out  1  to `alu64bit.cin`
- `alu_op`  out  2  to `alu64bit.op`
- `alu_s`  in  64  from `alu64bit.s`
- `alu_cout`  in  1  from `alu64bit.cout`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_s`  out  64  captured result
- `out_cout`  out  1  captured carry-out
- `op_count`  out  CNT_W  completed output handshakes, wraps modulo 2^CNT_W
- `out_zero`, `out_neg`  out  1 each  present only with `ALU_SEQ_FLAGS_EN`

## Operation
- FSM states are IDLE, SETTLE and DONE. All outputs are registered.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch `in_a`/`in_b`/`in_cin`/`in_op` into `alu_*`, clear the settle counter and go to SETTLE.
- **SETTLE**
  - `in_ready`=0. The counter increments each cycle.
  - On the edge where counter == `SETTLE_CYCLES`-1, capture `alu_s`→`out_s` and `alu_cout`→`out_cout`, set `out_valid`=1 and go to DONE.
- **DONE**
  - `in_ready`=0 and `out_valid`=1. `out_*` are held stable until the handshake completes.
  - On `out_ready`: clear `out_valid`, increment `op_count` and go to IDLE.
- The block processes one operation at a time. There is no overlap and no skid buffer.
- `alu_*` hold the last launched operands in every state. `out_s`/`out_cout` hold the last captured value after the handshake.
- `in_valid` in SETTLE/DONE is ignored. The request is not consumed because `in_ready`=0.
- `out_ready` outside DONE has no effect.
- `op_count` wraps from all-ones to 0 with no flag.

## Timing
- Reset (`rst_n`=0 at a rising edge): state=IDLE, `in_ready`=1, `out_valid`=0, `alu_a`/`alu_b`/`out_s`=0, `alu_cin`/`alu_op`/`out_cout`=0, `op_count`=0, counter=0, flags=0.
- Reset overrides every other input.
- Reset mid-SETTLE or mid-DONE abandons the operation. No result is emitted and `op_count` does not increment.
- Accept edge T (IDLE with `in_valid`=1): `alu_*` are valid from T.
- Capture edge is T+`SETTLE_CYCLES`, and `out_valid` rises there.
  - With `SETTLE_CYCLES`=1, capture happens on the first edge after acceptance.
- If `out_ready` is already high when DONE is entered, the handshake completes at T+`SETTLE_CYCLES`+1. `in_ready` returns to 1 from that same edge.
- Minimum throughput is one operation per `SETTLE_CYCLES`+2 cycles.
- `SETTLE_CYCLES` must cover the ALU's combinational delay. Integration sizes it from the worst-case ripple path against the clock period.

## Configuration
- `ALU_SEQ_FLAGS_EN` defined:
  - Adds ports `out_zero` and `out_neg`, captured on the same edge as `out_s`.
  - `out_zero` = (`alu_s`==0); `out_neg` = `alu_s[63]`.
  - Both are held and reset with `out_s`.
- `ALU_SEQ_FLAGS_EN` undefined: both ports and their registers are absent. All other behaviour is identical.

## Test plan
The bench uses an ALU stub with `alu_s` = `alu_a`+`alu_b`+`alu_cin` and `alu_cout` = carry, at `SETTLE_CYCLES`=4.

- **Basic add:** a=64'hFFFF_FFFF_FFFF_FFFF, b=0, op=2'b10, cin=0, `out_ready`=1 -> `out_valid` exactly 4 cycles after acceptance; `out_s`=64'hFFFF_FFFF_FFFF_FFFF, `out_cout`=0, `op_count`=1; with flags, zero=0 and neg=1.
- **Carry-out:** a=all ones, b=1, cin=0 -> `out_s`=0, `out_cout`=1; with flags, zero=1 and neg=0.
- **Output backpressure:** `out_ready`=0 for 10 cycles after `out_valid` -> `out_s` stable, `in_ready`=0, a second `in_valid` is not accepted; release `out_ready` -> handshake, then the second request is accepted next cycle.
- **Reset mid-SETTLE:** `rst_n`=0 two cycles after acceptance -> next edge gives `out_valid`=0, `in_ready`=1, `alu_a`=0, `op_count` unchanged; no result is emitted.
- **Counter wrap:** `CNT_W`=2, complete 5 operations -> `op_count` sequence 1,2,3,0,1.
- **Minimum latency:** `SETTLE_CYCLES`=1, back-to-back requests with `out_ready` tied high -> one result per 3 cycles, each equal to its own operands' sum.
